sopc_nios2_0_oci_dct_packer: RTL and testbench
==============================================

# sopc_nios2_0_oci_dct_packer

Packs 2-bit direct-control-transfer (DCT) trace codes from the Nios II OCI trace path into 15-slot, 30-bit frames. It sits directly upstream of the OCI test bench and trace FIFO. It drives the live `dct_buffer`/`dct_count` view consumed by the test bench, and hands completed frames downstream over a valid/ready handshake. It also detects and flags trace loss when the downstream side stalls.

## Interface
- `CODE_W`, 2, bits per DCT code (fixed; other values unsupported)
- `SLOTS`, 15, codes per frame; buffer width = `CODE_W*SLOTS` = 30
- `clk` in 1 — single clock, all logic rising-edge
- `reset` in 1 — asynchronous, active-high; clears all state
- `trace_enable` in 1 — codes accepted only while high
- `dct_code` in 2 — DCT code (00/01/10/11 per OCI encoding)
- `dct_code_valid` in 1 — `dct_code` valid this cycle
- `flush` in 1 — emit partial frame
- `frame_ready` in 1 — downstream accepts frame
- `frame_valid` out 1 — frame register holds a frame
- `frame_data` out 34 — {count[3:0], buffer[29:0]}
- `dct_buffer` out 30 — live accumulating buffer
- `dct_count` out 4 — live code count, 0..15
- `overflow` out 1 — sticky; a code was dropped
- `drop_count` out 8 — dropped-code counter, saturating

## Operation
- Reset values: `dct_buffer`=0, `dct_count`=0, `frame_valid`=0, `frame_data`=0, `overflow`=0, `drop_count`=0.
- Accept: `dct_code_valid & trace_enable` and a slot free.
  - Buffer shifts left by 2 and the new code enters bits [1:0]; the oldest code is in the MSBs.
  - `dct_count` increments.
- States:
  - EMPTY: count=0.
  - FILL: 1..14.
  - FULL: count=15, awaiting frame register.
- Emit: the accumulator moves to the frame register, and the accumulator clears to buffer=0, count=0. Emit is triggered by either:
  - count reaching 15 (including on the current accept), or
  - a flush request with count>0 (including the current accept).
- Emit occurs only if the frame register is empty or is being drained this cycle (`frame_valid & frame_ready`).
  - Otherwise the accumulator holds: FULL for a count-15 trigger; a pending flush is latched for a flush trigger.
- Drop: a code presented (`dct_code_valid & trace_enable`) while in FULL with no emit possible is discarded.
  - `overflow` is set (sticky until reset).
  - `drop_count` increments, saturating at 255.
- Simultaneous accept and emit when the accumulator was already FULL: the frame moves out, and the new code lands in the cleared accumulator with count=1.
- Flush request sources: `flush` pulse, or falling edge of `trace_enable`.
  - Flush with count=0 and no accept: no frame.
  - Pending flush is latched and serviced at the first emit opportunity.
- `trace_enable` low: codes ignored (not counted as drops); the existing accumulator is retained until flushed.
- Reset mid-frame discards the accumulator and the frame register contents.

## Timing
- Accept → `dct_buffer`/`dct_count` update: 1 cycle (registered).
- 15th accept at cycle N with frame register free → `frame_valid`=1 at N+1 with count field 15; `dct_count`=0 at N+1.
- `frame_data` is stable while `frame_valid & !frame_ready`.
- Transfer occurs on `frame_valid & frame_ready`. A new frame may load in the same cycle, giving back-to-back frames with no bubble.
- Flush → `frame_valid` at the next cycle when the register is free.
- `frame_valid` does not depend combinationally on `frame_ready`; no combinational input→output paths.

## Configuration
- `DCT_DROP_COUNT_EN` defined: 8-bit saturating `drop_count` implemented.
- Undefined: counter removed and `drop_count` tied to 0; `overflow` is still implemented.

## Test plan
- Reset, then 15 codes 01 with `frame_ready`=1 → `frame_valid` pulse one cycle later, `frame_data`={4'hF, 30'h15555555}, `dct_count`=0.
- Codes 11, 10, 00 then `flush` → `frame_data`={4'd3, 30'h00000038}.
- `frame_ready`=0; send 30 codes, then 2 more → first frame held, accumulator FULL, 2 codes dropped, `overflow`=1, `drop_count`=2; raise `frame_ready` → frames emitted in order, counts 15 and 15.
- FULL with `frame_ready`=1 and a new code 10 in the same cycle → frame transfers, `dct_count`=1, `dct_buffer`=30'h2.
- 5 codes then `trace_enable` falls → partial frame with count 5; codes while disabled ignored, `drop_count` unchanged.
- Assert `reset` with count 7 and `frame_valid`=1 → all outputs 0 asynchronously; 300 drops saturate `drop_count` at 255 (with `DCT_DROP_COUNT_EN`).

Source files
------------

// File: rtl/sopc_nios2_0_oci_dct_packer.sv
// Packs 2-bit OCI DCT trace codes into 15-slot frames with a valid/ready output.
// Optional: define DCT_DROP_COUNT_EN for the saturating dropped-code counter.
module sopc_nios2_0_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic [1:0]  dct_code,
  input  logic        dct_code_valid,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [33:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int BUF_W = CODE_W * SLOTS;
  localparam logic [3:0] CNT_FULL = 4'd15;

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic [33:0]      fd_q, fd_d;
  logic             pend_q, pend_d;
  logic             te_q, te_d;
  logic             ovf_q, ovf_d;
  logic             drop_ev;

  logic             in_v;
  logic             reg_free;
  logic             flush_req;
  logic [BUF_W-1:0] nb;
  logic [3:0]       nc;
  logic             trig;

  // Accumulate, emit to the frame register, or drop when stalled while full.
  always_comb begin
    in_v      = dct_code_valid & trace_enable;
    reg_free  = ~fv_q | frame_ready;
    flush_req = flush | (te_q & ~trace_enable) | pend_q;
    nb        = in_v ? {buf_q[BUF_W-3:0], dct_code} : buf_q;
    nc        = in_v ? cnt_q + 4'd1 : cnt_q;
    trig      = (nc == CNT_FULL) | (flush_req & (nc != 4'd0));
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q & ~frame_ready;
    fd_d      = fd_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    drop_ev   = 1'b0;
    te_d      = trace_enable;
    if (cnt_q == CNT_FULL) begin
      if (reg_free) begin
        fv_d   = 1'b1;
        fd_d   = {cnt_q, buf_q};
        buf_d  = in_v ? {{(BUF_W-2){1'b0}}, dct_code} : '0;
        cnt_d  = in_v ? 4'd1 : 4'd0;
        pend_d = 1'b0;
      end else begin
        // The full frame satisfies any flush once it moves out.
        pend_d  = flush_req;
        drop_ev = in_v;
        ovf_d   = ovf_q | in_v;
      end
    end else if (trig && reg_free) begin
      fv_d   = 1'b1;
      fd_d   = {nc, nb};
      buf_d  = '0;
      cnt_d  = 4'd0;
      pend_d = 1'b0;
    end else begin
      buf_d  = nb;
      cnt_d  = nc;
      pend_d = flush_req & (nc != 4'd0);
    end
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      fv_q   <= 1'b0;
      fd_q   <= '0;
      pend_q <= 1'b0;
      te_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
      fd_q   <= fd_d;
      pend_q <= pend_d;
      te_q   <= te_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of dropped codes.
  always_comb begin
    drop_d = drop_q;
    if (drop_ev && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_ev;
  assign drop_count  = 8'd0;
`endif

  assign frame_valid = fv_q;
  assign frame_data  = fd_q;
  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sopc_nios2_0_oci_dct_packer.sv
// Randomized bench for the DCT packer against a queue-based frame model.
// Build with DCT_DROP_COUNT_EN defined to exercise the drop counter.
module tb_sopc_nios2_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_enable;
  logic [1:0]  dct_code;
  logic        dct_code_valid;
  logic        flush;
  logic        frame_ready;
  logic        frame_valid;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  int          acc[$];
  bit          m_fv, m_pend, m_te, m_ovf;
  logic [33:0] m_fd;
  int          m_drop;

  always #5 clk = ~clk;

  sopc_nios2_0_oci_dct_packer dut (
    .clk(clk), .reset(reset), .trace_enable(trace_enable),
    .dct_code(dct_code), .dct_code_valid(dct_code_valid),
    .flush(flush), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_data(frame_data),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Oldest code in the most significant slot.
  function automatic logic [29:0] pack();
    logic [29:0] v = '0;
    foreach (acc[i]) v = v * 4 + 30'(acc[i]);
    return v;
  endfunction

  function automatic void m_reset();
    acc.delete();
    m_fv = 0; m_pend = 0; m_te = 0; m_ovf = 0; m_fd = '0; m_drop = 0;
  endfunction

  function automatic void m_emit();
    m_fd = {4'(acc.size()), pack()};
    m_fv = 1;
    acc.delete();
    m_pend = 0;
  endfunction

  function automatic void model_step();
    bit inv     = dct_code_valid && trace_enable;
    bit drained = m_fv && frame_ready;
    bit free    = !m_fv || drained;
    bit freq    = flush || (m_te && !trace_enable) || m_pend;
    bit emitted = 0;
    if (acc.size() == 15) begin
      if (free) begin
        m_emit();
        emitted = 1;
        if (inv) acc.push_back(int'(dct_code));
      end else begin
        m_pend = freq;
        if (inv) begin
          m_ovf = 1;
`ifdef DCT_DROP_COUNT_EN
          if (m_drop < 255) m_drop++;
`endif
        end
      end
    end else begin
      if (inv) acc.push_back(int'(dct_code));
      if (acc.size() == 15 || (freq && acc.size() > 0)) begin
        if (free) begin
          m_emit();
          emitted = 1;
        end else m_pend = freq;
      end else m_pend = 0;
    end
    if (!emitted && drained) m_fv = 0;
    m_te = trace_enable;
  endfunction

  task automatic check_all();
    chk("dct_buffer", dct_buffer, pack());
    chk("dct_count", dct_count, acc.size());
    chk("frame_valid", frame_valid, m_fv);
    chk("frame_data", frame_data, m_fd);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
  endtask

  task automatic cyc(input logic v, input logic [1:0] c, input logic te,
                     input logic fl, input logic rdy);
    dct_code_valid = v;
    dct_code       = c;
    trace_enable   = te;
    flush          = fl;
    frame_ready    = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    trace_enable   = 1'b0;
    dct_code       = 2'b00;
    dct_code_valid = 1'b0;
    flush          = 1'b0;
    frame_ready    = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 15 codes of 01 with the sink ready.
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 1, 0, 1);
    chk("tp1_valid", frame_valid, 1'b1);
    chk("tp1_data", frame_data, {4'hF, 30'h15555555});
    chk("tp1_count", dct_count, 4'd0);
    cyc(0, 2'b00, 1, 0, 1);

    // Partial frame via flush.
    cyc(1, 2'b11, 1, 0, 1);
    cyc(1, 2'b10, 1, 0, 1);
    cyc(1, 2'b00, 1, 0, 1);
    cyc(0, 2'b00, 1, 1, 1);
    chk("tp2_data", frame_data, {4'd3, 30'h00000038});
    cyc(0, 2'b00, 1, 0, 1);

    // Stalled sink: two frames queue up, then two drops.
    for (int i = 0; i < 32; i++) cyc(1, 2'(i), 1, 0, 0);
    chk("tp3_count", dct_count, 4'd15);
    chk("tp3_ovf", overflow, 1'b1);
    cyc(0, 2'b00, 1, 0, 1);
    chk("tp3_f2", frame_data[33:30], 4'd15);
    cyc(0, 2'b00, 1, 0, 1);
    chk("tp3_idle", frame_valid, 1'b0);

    // Full with a stalled frame, then drain and accept together.
    do_reset();
    for (int i = 0; i < 30; i++) cyc(1, 2'b11, 1, 0, 0);
    cyc(1, 2'b10, 1, 0, 1);
    chk("tp4_count", dct_count, 4'd1);
    chk("tp4_buf", dct_buffer, 30'h2);
    cyc(0, 2'b00, 1, 0, 1);

    // Five codes then trace_enable falls.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 2'b01, 1, 0, 1);
    cyc(1, 2'b11, 0, 0, 1);
    chk("tp5_data", frame_data, {4'd5, 30'h155});
    for (int i = 0; i < 4; i++) cyc(1, 2'b10, 0, 0, 1);
    chk("tp5_drop", drop_count, 8'd0);

    // Reset mid-frame with a frame pending.
    for (int i = 0; i < 22; i++) cyc(1, 2'b01, 1, 0, 0);
    chk("tp6_pre", dct_count, 4'd7);
    do_reset();

    // Saturation: 300 drops.
    for (int i = 0; i < 330; i++) cyc(1, 2'b10, 1, 0, 0);
`ifdef DCT_DROP_COUNT_EN
    chk("tp6_sat", drop_count, 8'd255);
`else
    chk("tp6_sat", drop_count, 8'd0);
`endif
    do_reset();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic rdy;
      rdy = ((i / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 15) != 0, $urandom_range(0, 15) == 0, rdy);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
